// File: rtl/design_switch_sequencer.sv
// design_switch_sequencer
//   Sequences a safe hand-over of the shared GPIO bank between selectable designs.
//   The raw select is synchronised and debounced. During a switch every design
//   is held in reset with the pads isolated. The new design is then released
//   from reset, and its chip select is enabled after a settle period.
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   sel_raw       asynchronous design select from pins (0 = none)
//   active_sel    design currently owning the GPIO bank (0 = none)
//   design_cs_n   active-low chip selects, bit i-1 = design i
//   design_rst    active-high per-design resets, bit i-1 = design i
//   gpio_isolate  1 = mux must park the pads (oeb all-1, out all-0)
//   busy          1 while qualifying or switching
//   switch_done   one-cycle pulse when a switch lands in RUN or OFF
module design_switch_sequencer #(
    parameter int unsigned NUM_DESIGNS     = 12,
    parameter int unsigned SEL_W           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       sel_raw,
    output logic [SEL_W-1:0]       active_sel,
    output logic [NUM_DESIGNS-1:0] design_cs_n,
    output logic [NUM_DESIGNS-1:0] design_rst,
    output logic                   gpio_isolate,
    output logic                   busy,
    output logic                   switch_done
);

    localparam int unsigned MaxAb  = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : RESET_CYCLES;
    localparam int unsigned MaxCnt = (MaxAb > SETTLE_CYCLES) ? MaxAb : SETTLE_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {StOff, StQual, StIsolate, StWake, StRun} state_e;

    logic [SEL_W-1:0]       sync1_q, sync2_q;
    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       cand_q, cand_d;
    logic [CntW-1:0]        cnt_q, cnt_d, cnt_next;
    logic                   from_run_q, from_run_d;
    logic [SEL_W-1:0]       active_q, active_d;
    logic [NUM_DESIGNS-1:0] cs_n_q, cs_n_d, drst_q, drst_d, sel_onehot;
    logic                   iso_q, iso_d, busy_q, busy_d, done_q, done_d;
    logic [SEL_W-1:0]       cand;

    // Out-of-range codes behave as "no design".
    assign cand = (sync2_q > SEL_W'(NUM_DESIGNS)) ? '0 : sync2_q;

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        from_run_d = from_run_q;
        active_d   = active_q;
        done_d     = 1'b0;
        cnt_next   = '0;
        unique case (state_q)
            StOff, StRun: begin
                if (cand != active_q) begin
                    state_d    = StQual;
                    cand_d     = cand;
                    cnt_d      = '0;
                    from_run_d = (state_q == StRun);
                end
            end
            StQual: begin
                if (cand == active_q) begin
                    // Select bounced back to the owner: abandon without a switch.
                    state_d = from_run_q ? StRun : StOff;
                    cnt_d   = '0;
                end else begin
                    cnt_next = (cand != cand_q) ? CntW'(1) : cnt_q + CntW'(1);
                    cand_d   = cand;
                    if (cnt_next >= CntW'(DEBOUNCE_CYCLES)) begin
                        state_d = StIsolate;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            StIsolate: begin
                if (cnt_q == CntW'(RESET_CYCLES - 1)) begin
                    cnt_d    = '0;
                    active_d = cand_q;
                    if (cand_q == '0) begin
                        state_d = StOff;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StWake;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWake: begin
                if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StRun;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StOff;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        sel_onehot = '0;
        if (active_d != '0) begin
            sel_onehot = NUM_DESIGNS'(1) << (active_d - SEL_W'(1));
        end
        cs_n_d = '1;
        drst_d = '1;
        iso_d  = 1'b1;
        busy_d = 1'b0;
        unique case (state_d)
            StQual: begin
                busy_d = 1'b1;
                // The current design keeps running while a new select qualifies.
                if (from_run_d) begin
                    cs_n_d = ~sel_onehot;
                    drst_d = ~sel_onehot;
                    iso_d  = 1'b0;
                end
            end
            StIsolate: busy_d = 1'b1;
            StWake: begin
                busy_d = 1'b1;
                drst_d = ~sel_onehot;
            end
            StRun: begin
                cs_n_d = ~sel_onehot;
                drst_d = ~sel_onehot;
                iso_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= StOff;
            cand_q     <= '0;
            cnt_q      <= '0;
            from_run_q <= 1'b0;
            active_q   <= '0;
            cs_n_q     <= '1;
            drst_q     <= '1;
            iso_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sync1_q    <= sel_raw;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            from_run_q <= from_run_d;
            active_q   <= active_d;
            cs_n_q     <= cs_n_d;
            drst_q     <= drst_d;
            iso_q      <= iso_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign active_sel   = active_q;
    assign design_cs_n  = cs_n_q;
    assign design_rst   = drst_q;
    assign gpio_isolate = iso_q;
    assign busy         = busy_q;
    assign switch_done  = done_q;

endmodule

// File: tb/tb_design_switch_sequencer.sv
module tb_design_switch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel_raw;
    logic [3:0]  active_sel;
    logic [11:0] design_cs_n;
    logic [11:0] design_rst;
    logic        gpio_isolate;
    logic        busy;
    logic        switch_done;

    int n_checks = 0;
    int n_errors = 0;

    design_switch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .sel_raw      (sel_raw),
        .active_sel   (active_sel),
        .design_cs_n  (design_cs_n),
        .design_rst   (design_rst),
        .gpio_isolate (gpio_isolate),
        .busy         (busy),
        .switch_done  (switch_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".active"}, 32'(active_sel), 32'h0);
        check_eq({tag, ".cs_n"},   32'(design_cs_n), 32'hFFF);
        check_eq({tag, ".rst"},    32'(design_rst), 32'hFFF);
        check_eq({tag, ".iso"},    32'(gpio_isolate), 32'h1);
        check_eq({tag, ".busy"},   32'(busy), 32'h0);
        check_eq({tag, ".done"},   32'(switch_done), 32'h0);
    endtask

    initial begin
        logic seen_done;
        logic cs_moved;

        // 1: reset
        rst = 1'b1;
        sel_raw = 4'd0;
        step(2);
        check_reset_vals("reset");
        rst = 1'b0;
        step(3);
        check_reset_vals("idle_off");

        // 2: OFF -> 5. Edge 2 loads cand (cycle T), QUAL after edge 3.
        sel_raw = 4'd5;
        step(2);
        check_eq("sw5.T_busy", 32'(busy), 32'h0);
        step(1);
        check_eq("sw5.qual_busy", 32'(busy), 32'h1);
        check_eq("sw5.qual_cs", 32'(design_cs_n), 32'hFFF);
        step(23);  // edge 26: still isolating
        check_eq("sw5.iso_end_rst", 32'(design_rst), 32'hFFF);
        step(1);   // edge 27: WAKE
        check_eq("sw5.wake_rst", 32'(design_rst), 32'hFEF);
        check_eq("sw5.wake_cs", 32'(design_cs_n), 32'hFFF);
        check_eq("sw5.wake_iso", 32'(gpio_isolate), 32'h1);
        check_eq("sw5.wake_active", 32'(active_sel), 32'h5);
        step(3);   // edge 30
        check_eq("sw5.pre_run_cs", 32'(design_cs_n), 32'hFFF);
        check_eq("sw5.pre_run_done", 32'(switch_done), 32'h0);
        step(1);   // edge 31: RUN
        check_eq("sw5.run_cs", 32'(design_cs_n), 32'hFEF);
        check_eq("sw5.run_iso", 32'(gpio_isolate), 32'h0);
        check_eq("sw5.run_done", 32'(switch_done), 32'h1);
        check_eq("sw5.run_busy", 32'(busy), 32'h0);
        step(1);
        check_eq("sw5.done_pulse", 32'(switch_done), 32'h0);

        // 3: glitch to 9 for three cycles, back to 5
        step(2);
        sel_raw = 4'd9;
        step(3);
        sel_raw = 4'd5;
        check_eq("glitch.busy", 32'(busy), 32'h1);
        check_eq("glitch.cs", 32'(design_cs_n), 32'hFEF);
        seen_done = 1'b0;
        cs_moved = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            seen_done |= switch_done;
            cs_moved |= (design_cs_n != 12'hFEF);
        end
        check_eq("glitch.no_done", 32'(seen_done), 32'h0);
        check_eq("glitch.cs_held", 32'(cs_moved), 32'h0);
        check_eq("glitch.busy_end", 32'(busy), 32'h0);

        // 4: RUN(5) -> 8
        sel_raw = 4'd8;
        step(10);  // edge 10: still qualifying, old design runs
        check_eq("sw8.qual_cs", 32'(design_cs_n), 32'hFEF);
        check_eq("sw8.qual_iso", 32'(gpio_isolate), 32'h0);
        step(1);   // edge 11: ISOLATE
        check_eq("sw8.iso_cs", 32'(design_cs_n), 32'hFFF);
        check_eq("sw8.iso_rst", 32'(design_rst), 32'hFFF);
        check_eq("sw8.iso_iso", 32'(gpio_isolate), 32'h1);
        step(15);  // edge 26: 16th isolate cycle
        check_eq("sw8.iso16_rst", 32'(design_rst), 32'hFFF);
        step(1);
        check_eq("sw8.wake_rst", 32'(design_rst), 32'hF7F);
        check_eq("sw8.wake_cs", 32'(design_cs_n), 32'hFFF);
        step(4);
        check_eq("sw8.run_cs", 32'(design_cs_n), 32'hF7F);
        check_eq("sw8.run_done", 32'(switch_done), 32'h1);

        // 5: -> 9, then out-of-range 14 -> OFF
        sel_raw = 4'd9;
        step(31);
        check_eq("sw9.run_cs", 32'(design_cs_n), 32'hEFF);
        check_eq("sw9.active", 32'(active_sel), 32'h9);
        sel_raw = 4'd14;
        step(26);
        check_eq("off.iso_busy", 32'(busy), 32'h1);
        step(1);
        check_eq("off.active", 32'(active_sel), 32'h0);
        check_eq("off.done", 32'(switch_done), 32'h1);
        check_eq("off.iso", 32'(gpio_isolate), 32'h1);
        check_eq("off.cs", 32'(design_cs_n), 32'hFFF);
        check_eq("off.rst", 32'(design_rst), 32'hFFF);
        check_eq("off.busy", 32'(busy), 32'h0);
        step(4);
        check_eq("off.stays_busy", 32'(busy), 32'h0);

        // 6: reset mid-ISOLATE, then mid-WAKE
        sel_raw = 4'd3;
        step(15);
        check_eq("rst_iso.pre_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step(1);
        check_reset_vals("rst_iso");
        rst = 1'b0;
        step(28);  // requalified from scratch, now in WAKE
        check_eq("rst_wake.pre_rst", 32'(design_rst), 32'hFFB);
        rst = 1'b1;
        step(1);
        check_reset_vals("rst_wake");
        rst = 1'b0;
        step(30);
        check_eq("rst_wake.pre_run_cs", 32'(design_cs_n), 32'hFFF);
        step(1);
        check_eq("rst_wake.run_cs", 32'(design_cs_n), 32'hFFB);
        check_eq("rst_wake.run_active", 32'(active_sel), 32'h3);
        check_eq("rst_wake.run_done", 32'(switch_done), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
